// File: rtl/ps2_key_controller.sv
// PS/2 keyboard controller: sends the keyboard reset command (FF), waits for ACK and BAT,
// then decodes set-2 scan codes into events and held-key levels for a game pad style mapping.
module ps2_key_controller #(
    parameter int ACK_TIMEOUT = 2500000,
    parameter int BAT_TIMEOUT = 50000000,
    parameter int RETRY_MAX   = 3
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    input  logic       command_was_sent,
    input  logic       error_communication_timed_out,
    input  logic       init_req,
    output logic [7:0] the_command,
    output logic       send_command,
    output logic       key_left,
    output logic       key_right,
    output logic       key_down,
    output logic       key_jump,
    output logic       key_event,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       init_done,
    output logic       init_error
);

    typedef enum logic [2:0] {C_SEND, C_GAP, C_WAIT_ACK, C_WAIT_BAT, C_DONE, C_ERR} cmd_state_t;
    typedef enum logic [1:0] {D_IDLE, D_EXT, D_BRK, D_EXT_BRK} dec_state_t;

    localparam int ATT_W = ($clog2(RETRY_MAX + 1) < 2) ? 2 : $clog2(RETRY_MAX + 1);
    localparam logic [25:0]      ACK_LIMIT   = 26'(ACK_TIMEOUT);
    localparam logic [25:0]      BAT_LIMIT   = 26'(BAT_TIMEOUT);
    localparam logic [ATT_W-1:0] RETRY_LIMIT = ATT_W'(RETRY_MAX);

    cmd_state_t       cmd_q, cmd_d;
    dec_state_t       dec_q, dec_d;
    logic             gap_retry_q, gap_retry_d;
    logic [25:0]      timer_q, timer_d;
    logic [ATT_W-1:0] attempt_q, attempt_d;
    logic             send_command_q, send_command_d;
    logic             init_done_q, init_done_d;
    logic             init_error_q, init_error_d;
    logic             key_event_q, key_event_d;
    logic [7:0]       key_code_q, key_code_d;
    logic             key_ext_q, key_ext_d;
    logic             key_break_q, key_break_d;
    logic             left_q, left_d, right_q, right_d, down_q, down_d;
    logic             up_q, up_d, space_q, space_d;

    logic retry, retry_via_gap, is_special, was_ext, was_brk, make;

    // Command sequencer
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        cmd_d         = cmd_q;
        gap_retry_d   = gap_retry_q;
        attempt_d     = attempt_q;
        retry         = 1'b0;
        retry_via_gap = 1'b0;
        case (cmd_q)
            C_SEND: begin
                if (command_was_sent) begin
                    cmd_d       = C_GAP;
                    gap_retry_d = 1'b0;
                end else if (error_communication_timed_out) begin
                    retry         = 1'b1;
                    retry_via_gap = 1'b1;
                end
            end
            C_GAP:      cmd_d = gap_retry_q ? C_SEND : C_WAIT_ACK;
            C_WAIT_ACK: begin
                if (received_data_en && received_data == 8'hFA) cmd_d = C_WAIT_BAT;
                else if ((received_data_en && received_data == 8'hFE) || timer_q >= ACK_LIMIT)
                    retry = 1'b1;
            end
            C_WAIT_BAT: begin
                if (received_data_en && received_data == 8'hAA) cmd_d = C_DONE;
                else if ((received_data_en && received_data == 8'hFC) || timer_q >= BAT_LIMIT)
                    retry = 1'b1;
            end
            default: cmd_d = cmd_q;
        endcase

        if (retry) begin
            attempt_d = attempt_q + 1'b1;
            if (attempt_d == RETRY_LIMIT) begin
                cmd_d = C_ERR;
            end else if (retry_via_gap) begin
                cmd_d       = C_GAP;
                gap_retry_d = 1'b1;
            end else begin
                cmd_d = C_SEND;
            end
        end

        if (init_req) begin
            cmd_d       = C_SEND;
            attempt_d   = '0;
            gap_retry_d = 1'b0;
        end

        // Restart the timeout window on every state entry, including a self-re-entry via init_req.
        if (cmd_d != cmd_q || init_req) timer_d = '0;
        else if (&timer_q)              timer_d = timer_q;
        else                            timer_d = timer_q + 26'd1;

        send_command_d = (cmd_d == C_SEND);
        init_done_d    = (cmd_d == C_DONE);
        init_error_d   = (cmd_d == C_ERR);
    end

    // Scan-code decoder, live only once the keyboard has finished its self-test
    always_comb begin
        dec_d       = dec_q;
        key_event_d = 1'b0;
        key_code_d  = key_code_q;
        key_ext_d   = key_ext_q;
        key_break_d = key_break_q;
        left_d      = left_q;
        right_d     = right_q;
        down_d      = down_q;
        up_d        = up_q;
        space_d     = space_q;
        was_ext     = (dec_q == D_EXT) || (dec_q == D_EXT_BRK);
        was_brk     = (dec_q == D_BRK) || (dec_q == D_EXT_BRK);
        make        = !was_brk;
        is_special  = (received_data == 8'hFA) || (received_data == 8'hAA) ||
                      (received_data == 8'hEE) || (received_data == 8'hFE) ||
                      (received_data == 8'h00) || (received_data == 8'hFF);

        if (init_req) begin
            dec_d   = D_IDLE;
            left_d  = 1'b0;
            right_d = 1'b0;
            down_d  = 1'b0;
            up_d    = 1'b0;
            space_d = 1'b0;
        end else if (cmd_q == C_DONE && received_data_en) begin
            if (is_special)                                     dec_d = D_IDLE;
            else if (received_data == 8'hE0 && dec_q == D_IDLE) dec_d = D_EXT;
            else if (received_data == 8'hF0 && dec_q == D_IDLE) dec_d = D_BRK;
            else if (received_data == 8'hF0 && dec_q == D_EXT)  dec_d = D_EXT_BRK;
            else begin
                dec_d       = D_IDLE;
                key_event_d = 1'b1;
                key_code_d  = received_data;
                key_ext_d   = was_ext;
                key_break_d = was_brk;
                if (was_ext) begin
                    case (received_data)
                        8'h6B:   left_d  = make;
                        8'h74:   right_d = make;
                        8'h72:   down_d  = make;
                        8'h75:   up_d    = make;
                        default: ;
                    endcase
                end else if (received_data == 8'h29) begin
                    space_d = make;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            cmd_q          <= C_SEND;
            dec_q          <= D_IDLE;
            gap_retry_q    <= 1'b0;
            timer_q        <= '0;
            attempt_q      <= '0;
            send_command_q <= 1'b0;
            init_done_q    <= 1'b0;
            init_error_q   <= 1'b0;
            key_event_q    <= 1'b0;
            key_code_q     <= 8'h00;
            key_ext_q      <= 1'b0;
            key_break_q    <= 1'b0;
            left_q         <= 1'b0;
            right_q        <= 1'b0;
            down_q         <= 1'b0;
            up_q           <= 1'b0;
            space_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            cmd_q          <= cmd_d;
            dec_q          <= dec_d;
            gap_retry_q    <= gap_retry_d;
            timer_q        <= timer_d;
            attempt_q      <= attempt_d;
            send_command_q <= send_command_d;
            init_done_q    <= init_done_d;
            init_error_q   <= init_error_d;
            key_event_q    <= key_event_d;
            key_code_q     <= key_code_d;
            key_ext_q      <= key_ext_d;
            key_break_q    <= key_break_d;
            left_q         <= left_d;
            right_q        <= right_d;
            down_q         <= down_d;
            up_q           <= up_d;
            space_q        <= space_d;
        end
    end

    assign the_command  = 8'hFF;
    assign send_command = send_command_q;
    assign init_done    = init_done_q;
    assign init_error   = init_error_q;
    assign key_event    = key_event_q;
    assign key_code     = key_code_q;
    assign key_ext      = key_ext_q;
    assign key_break    = key_break_q;
    assign key_left     = left_q;
    assign key_right    = right_q;
    assign key_down     = down_q;
    assign key_jump     = up_q | space_q;

endmodule

// File: tb/tb_ps2_key_controller.sv
// Directed bench for ps2_key_controller: init handshake, retries, scan decoding and held keys.
module tb_ps2_key_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] received_data;
    logic       received_data_en;
    logic       command_was_sent;
    logic       error_communication_timed_out;
    logic       init_req;
    logic [7:0] the_command;
    logic       send_command;
    logic       key_left, key_right, key_down, key_jump;
    logic       key_event;
    logic [7:0] key_code;
    logic       key_ext, key_break;
    logic       init_done, init_error;

    int checks = 0;
    int errors = 0;

    ps2_key_controller #(
        .ACK_TIMEOUT(20),
        .BAT_TIMEOUT(40),
        .RETRY_MAX  (3)
    ) dut (
        .CLOCK_50                      (clk),
        .reset                         (rst),
        .received_data                 (received_data),
        .received_data_en              (received_data_en),
        .command_was_sent              (command_was_sent),
        .error_communication_timed_out (error_communication_timed_out),
        .init_req                      (init_req),
        .the_command                   (the_command),
        .send_command                  (send_command),
        .key_left                      (key_left),
        .key_right                     (key_right),
        .key_down                      (key_down),
        .key_jump                      (key_jump),
        .key_event                     (key_event),
        .key_code                      (key_code),
        .key_ext                       (key_ext),
        .key_break                     (key_break),
        .init_done                     (init_done),
        .init_error                    (init_error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        received_data    = b;
        received_data_en = 1'b1;
        tick();
        received_data_en = 1'b0;
    endtask

    task automatic pulse_init_req();
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
    endtask

    task automatic wait_send(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (send_command === 1'b1) seen = 1'b1;
            else tick();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: send_command got 0 for 100 cycles, want 1", name);
        end
    endtask

    // Waits for a send request, completes it, and lets the one-cycle gap pass.
    task automatic finish_send(input string name);
        wait_send(name);
        command_was_sent = 1'b1;
        tick();
        command_was_sent = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (send_command !== 1'b0) begin errors++; $display("FAIL reset_send: got %b want 0", send_command); end
        checks++; if (the_command !== 8'hFF) begin errors++; $display("FAIL reset_cmd: got %h want ff", the_command); end
        checks++; if ({init_done, init_error} !== 2'b00) begin errors++; $display("FAIL reset_status: got %b want 00", {init_done, init_error}); end
        checks++; if ({key_left, key_right, key_down, key_jump, key_event, key_ext, key_break} !== 7'b0)
            begin errors++; $display("FAIL reset_keys: got %b want 0000000", {key_left, key_right, key_down, key_jump, key_event, key_ext, key_break}); end
        checks++; if (key_code !== 8'h00) begin errors++; $display("FAIL reset_code: got %h want 00", key_code); end
        rst = 1'b0;
        tick();
        checks++; if (send_command !== 1'b1) begin errors++; $display("FAIL release_send: got %b want 1", send_command); end
    endtask

    task automatic test_init_ok();
        tick(); tick(); tick();
        checks++; if (send_command !== 1'b1) begin errors++; $display("FAIL send_hold: got %b want 1", send_command); end
        command_was_sent = 1'b1;
        tick();
        command_was_sent = 1'b0;
        checks++; if (send_command !== 1'b0) begin errors++; $display("FAIL send_drop: got %b want 0", send_command); end
        tick();
        send_byte(8'h6B);
        checks++; if (key_event !== 1'b0) begin errors++; $display("FAIL predone_event: got %b want 0", key_event); end
        send_byte(8'hFA);
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL ack_only_done: got %b want 0", init_done); end
        send_byte(8'hAA);
        checks++; if ({init_done, init_error, send_command} !== 3'b100)
            begin errors++; $display("FAIL init_ok: got done/err/send %b want 100", {init_done, init_error, send_command}); end
        checks++; if (key_event !== 1'b0) begin errors++; $display("FAIL bat_event: got %b want 0", key_event); end
    endtask

    task automatic test_keys();
        send_byte(8'hE0);
        send_byte(8'h6B);
        checks++; if ({key_event, key_left, key_ext, key_break} !== 4'b1110)
            begin errors++; $display("FAIL left_make: got ev/left/ext/brk %b want 1110", {key_event, key_left, key_ext, key_break}); end
        checks++; if (key_code !== 8'h6B) begin errors++; $display("FAIL left_code: got %h want 6b", key_code); end
        tick();
        checks++; if ({key_event, key_code} !== {1'b0, 8'h6B})
            begin errors++; $display("FAIL event_hold: got ev/code %b/%h want 0/6b", key_event, key_code); end
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h6B);
        checks++; if ({key_event, key_left, key_ext, key_break} !== 4'b1011)
            begin errors++; $display("FAIL left_break: got ev/left/ext/brk %b want 1011", {key_event, key_left, key_ext, key_break}); end
    endtask

    task automatic test_jump();
        send_byte(8'hE0);
        send_byte(8'h75);
        checks++; if (key_jump !== 1'b1) begin errors++; $display("FAIL up_make: got %b want 1", key_jump); end
        send_byte(8'h29);
        checks++; if ({key_jump, key_ext, key_code} !== {2'b10, 8'h29})
            begin errors++; $display("FAIL space_make: got jump/ext/code %b/%b/%h want 1/0/29", key_jump, key_ext, key_code); end
        send_byte(8'hF0);
        send_byte(8'h29);
        checks++; if ({key_jump, key_break, key_event} !== 3'b111)
            begin errors++; $display("FAIL space_break: got jump/brk/ev %b want 111", {key_jump, key_break, key_event}); end
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        checks++; if (key_jump !== 1'b0) begin errors++; $display("FAIL up_break: got %b want 0", key_jump); end
    endtask

    task automatic test_decoder_misc();
        send_byte(8'hE0);
        send_byte(8'hFA);
        checks++; if (key_event !== 1'b0) begin errors++; $display("FAIL special_event: got %b want 0", key_event); end
        send_byte(8'h6B);
        checks++; if ({key_event, key_ext, key_left} !== 3'b100)
            begin errors++; $display("FAIL special_reset: got ev/ext/left %b want 100", {key_event, key_ext, key_left}); end
        send_byte(8'h1C);
        checks++; if ({key_event, key_left, key_right, key_down, key_jump} !== 5'b10000)
            begin errors++; $display("FAIL unmapped: got ev/l/r/d/j %b want 10000", {key_event, key_left, key_right, key_down, key_jump}); end
        send_byte(8'hE0);
        send_byte(8'h74);
        send_byte(8'hE0);
        send_byte(8'h74);
        checks++; if ({key_event, key_right} !== 2'b11) begin errors++; $display("FAIL repeat_make: got ev/right %b want 11", {key_event, key_right}); end
        send_byte(8'hE0);
        send_byte(8'h72);
        checks++; if ({key_down, key_right} !== 2'b11) begin errors++; $display("FAIL down_make: got down/right %b want 11", {key_down, key_right}); end
    endtask

    task automatic test_init_req();
        pulse_init_req();
        checks++; if ({key_left, key_right, key_down, key_jump, init_done} !== 5'b0)
            begin errors++; $display("FAIL initreq_clear: got l/r/d/j/done %b want 00000", {key_left, key_right, key_down, key_jump, init_done}); end
        checks++; if (send_command !== 1'b1) begin errors++; $display("FAIL initreq_send: got %b want 1", send_command); end
        tick();
        checks++; if (send_command !== 1'b1) begin errors++; $display("FAIL initreq_send2: got %b want 1", send_command); end
    endtask

    task automatic test_nak();
        finish_send("nak_send1");
        send_byte(8'hFE);
        checks++; if ({send_command, init_error} !== 2'b10) begin errors++; $display("FAIL nak_resend: got send/err %b want 10", {send_command, init_error}); end
        finish_send("nak_send2");
        send_byte(8'hFA);
        send_byte(8'hAA);
        checks++; if ({init_done, init_error} !== 2'b10) begin errors++; $display("FAIL nak_recover: got done/err %b want 10", {init_done, init_error}); end
    endtask

    task automatic test_ack_timeout();
        bit seen = 1'b0;
        bit resent = 1'b0;
        pulse_init_req();
        for (int a = 0; a < 3; a++) begin
            wait_send("to_send");
            checks++; if (init_error !== 1'b0) begin errors++; $display("FAIL to_early_err attempt %0d: got 1 want 0", a); end
            command_was_sent = 1'b1;
            tick();
            command_was_sent = 1'b0;
        end
        for (int i = 0; i < 100 && !seen; i++) begin
            if (init_error === 1'b1) seen = 1'b1;
            else tick();
        end
        checks++; if (!seen) begin errors++; $display("FAIL to_error: init_error got 0 for 100 cycles, want 1"); end
        for (int i = 0; i < 50; i++) begin
            if (send_command !== 1'b0) resent = 1'b1;
            tick();
        end
        checks++; if (resent || init_error !== 1'b1)
            begin errors++; $display("FAIL to_stuck: got resent/err %b/%b want 0/1", resent, init_error); end
    endtask

    task automatic test_tx_error();
        pulse_init_req();
        checks++; if (init_error !== 1'b0) begin errors++; $display("FAIL txerr_clear: got %b want 0", init_error); end
        for (int a = 0; a < 3; a++) begin
            wait_send("txerr_send");
            error_communication_timed_out = 1'b1;
            tick();
            error_communication_timed_out = 1'b0;
        end
        checks++; if ({init_error, send_command} !== 2'b10)
            begin errors++; $display("FAIL txerr_final: got err/send %b want 10", {init_error, send_command}); end
    endtask

    task automatic test_reset_mid();
        pulse_init_req();
        finish_send("mid_s1");
        send_byte(8'hFE);
        finish_send("mid_s2");
        send_byte(8'hFE);
        wait_send("mid_s3");
        #2 rst = 1'b1;
        #1;
        checks++; if ({send_command, init_error, init_done} !== 3'b000)
            begin errors++; $display("FAIL async_reset: got send/err/done %b want 000", {send_command, init_error, init_done}); end
        tick();
        rst = 1'b0;
        finish_send("post_s1");
        send_byte(8'hFE);
        finish_send("post_s2");
        send_byte(8'hFE);
        finish_send("post_s3");
        send_byte(8'hFA);
        send_byte(8'hAA);
        checks++; if ({init_done, init_error} !== 2'b10)
            begin errors++; $display("FAIL attempts_cleared: got done/err %b want 10", {init_done, init_error}); end
    endtask

    initial begin
        rst                           = 1'b1;
        received_data                 = 8'h00;
        received_data_en              = 1'b0;
        command_was_sent              = 1'b0;
        error_communication_timed_out = 1'b0;
        init_req                      = 1'b0;
        #1;
        test_reset();
        test_init_ok();
        test_keys();
        test_jump();
        test_decoder_misc();
        test_init_req();
        test_nak();
        test_ack_timeout();
        test_tx_error();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000 ns, want finished");
        $fatal(1, "watchdog expired");
    end

endmodule
